// File: rtl/wishbone_arbiter_if.sv
// Bundle of the requester-side and downstream Wishbone signals shared by wishbone_arbiter.
// The slave modport is the arbiter's view. The master modport is the requesters plus the downstream target.
interface wishbone_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 32
);
  logic [NUM_MASTERS-1:0]            M_CYC;
  logic [NUM_MASTERS-1:0]            M_STB;
  logic [NUM_MASTERS-1:0]            M_WE;
  logic [NUM_MASTERS-1:0]            M_RD;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_ADR;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] M_WR_DAT;
  logic [NUM_MASTERS*4-1:0]          M_BYTE_STB;
  logic [NUM_MASTERS-1:0]            M_ACK;
  logic [NUM_MASTERS-1:0]            M_ERR;
  logic [DATA_WIDTH-1:0]             M_RD_DAT;
  logic                              WB_CYC;
  logic                              WB_STB;
  logic                              WB_WE;
  logic                              WB_RD;
  logic [ADDR_WIDTH-1:0]             WB_ADR;
  logic [DATA_WIDTH-1:0]             WB_WR_DAT;
  logic [3:0]                        WB_BYTE_STB;
  logic [DATA_WIDTH-1:0]             WB_RD_DAT;
  logic                              WB_ACK;
  logic [NUM_MASTERS-1:0]            GNT;

  modport slave (
    input  M_CYC, M_STB, M_WE, M_RD, M_ADR, M_WR_DAT, M_BYTE_STB, WB_RD_DAT, WB_ACK,
    output M_ACK, M_ERR, M_RD_DAT, WB_CYC, WB_STB, WB_WE, WB_RD, WB_ADR, WB_WR_DAT,
           WB_BYTE_STB, GNT
  );

  modport master (
    output M_CYC, M_STB, M_WE, M_RD, M_ADR, M_WR_DAT, M_BYTE_STB, WB_RD_DAT, WB_ACK,
    input  M_ACK, M_ERR, M_RD_DAT, WB_CYC, WB_STB, WB_WE, WB_RD, WB_ADR, WB_WR_DAT,
           WB_BYTE_STB, GNT
  );
endinterface

// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone arbiter: grants whole CYC tenancies, 1-cycle arbitration, zero-latency beats; losers wait with ACK=0.
// Optional stall watchdog under WB_ARB_TIMEOUT_EN (errors the stuck beat and releases the bus).
module wishbone_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 17,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  WB_CLK,
  input  logic                  WB_RST,
  wishbone_arbiter_if.slave     bus
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic                  rd;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
    logic [3:0]            sel;
  } req_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;

  req_t                   sel_req;
  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       cand;
  logic                   drive;
  logic                   tmo_hit;
  logic [NUM_MASTERS-1:0] m_ack;
  logic [NUM_MASTERS-1:0] m_err;
  logic [DATA_WIDTH-1:0]  rd_dat;

  always_comb begin
    sel_req.cyc = bus.M_CYC[gidx_q];
    sel_req.stb = bus.M_STB[gidx_q];
    sel_req.we  = bus.M_WE[gidx_q];
    sel_req.rd  = bus.M_RD[gidx_q];
    sel_req.adr = bus.M_ADR[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
    sel_req.dat = bus.M_WR_DAT[gidx_q*DATA_WIDTH +: DATA_WIDTH];
    sel_req.sel = bus.M_BYTE_STB[gidx_q*4 +: 4];
  end

  // Scan from the farthest candidate down so the nearest requester after the pointer wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_MASTERS);
      if (bus.M_CYC[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Keyed off the registered count only, so WB_ACK never reaches WB_CYC/WB_STB combinationally;
  // an ACK landing on the expiry cycle itself is swallowed by the error response.
  assign tmo_hit = (state_q == BUSY) && sel_req.cyc && sel_req.stb &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != BUSY || bus.WB_ACK || tmo_hit) begin
      cnt_d = '0;
    end else if (sel_req.cyc && sel_req.stb) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge WB_CLK or negedge WB_RST) begin
    if (!WB_RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign tmo_hit = 1'b0;
`endif

  assign drive           = (state_q == BUSY) && sel_req.cyc && !tmo_hit;
  assign bus.WB_CYC      = drive;
  assign bus.WB_STB      = drive && sel_req.stb;
  assign bus.WB_WE       = drive && sel_req.we;
  assign bus.WB_RD       = drive && sel_req.rd;
  assign bus.WB_ADR      = drive ? sel_req.adr : '0;
  assign bus.WB_WR_DAT   = drive ? sel_req.dat : '0;
  assign bus.WB_BYTE_STB = drive ? sel_req.sel : 4'h0;
  assign bus.GNT         = gnt_q;

  always_comb begin
    m_ack  = '0;
    m_err  = '0;
    rd_dat = bus.WB_RD_DAT;
    if (state_q == BUSY) begin
      m_ack[gidx_q] = bus.WB_ACK;
    end
`ifdef WB_ARB_TIMEOUT_EN
    if (tmo_hit) begin
      m_ack[gidx_q] = 1'b1;
      m_err[gidx_q] = 1'b1;
      rd_dat        = DATA_WIDTH'(32'hDEAD_BEEF);
    end
`endif
  end

  assign bus.M_ACK    = m_ack;
  assign bus.M_ERR    = m_err;
  assign bus.M_RD_DAT = rd_dat;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d        = BUSY;
          gidx_d         = win_idx;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
        end
      end
      BUSY: begin
        if (!sel_req.cyc || tmo_hit) begin
          state_d = IDLE;
          ptr_d   = gidx_q;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge WB_CLK or negedge WB_RST) begin
    if (!WB_RST) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench for wishbone_arbiter: cycle vector table with an ACK scoreboard, plus reset, round-robin and watchdog sequences.
`timescale 1ns/1ps
module tb_wishbone_arbiter;
  localparam int NM  = 2;
  localparam int AW  = 17;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wishbone_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  wishbone_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .WB_CLK (clk),
    .WB_RST (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        rst_n;
    logic [1:0]  cyc;
    logic [1:0]  we;
    logic        ack;
    logic [31:0] rdat;
    logic        wcyc;
    logic [1:0]  gnt;
    logic [1:0]  mack;
  } vec_t;

  typedef struct {
    int unsigned mst;
    logic [31:0] dat;
  } sb_t;

  vec_t vt[$];
  sb_t  sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [AW-1:0] adr_tab [NM];
  logic [DW-1:0] dat_tab [NM];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic addv(input logic r, input logic [1:0] c, input logic [1:0] w, input logic a,
                      input logic [31:0] d, input logic ec, input logic [1:0] eg,
                      input logic [1:0] ea);
    vec_t v;
    v.rst_n = r; v.cyc = c; v.we = w; v.ack = a; v.rdat = d;
    v.wcyc = ec; v.gnt = eg; v.mack = ea;
    vt.push_back(v);
  endtask

  task automatic drive(input logic [1:0] c, input logic [1:0] w, input logic a,
                       input logic [31:0] d);
    bus.M_CYC     = c;
    bus.M_STB     = c;
    bus.M_WE      = w;
    bus.M_RD      = c & ~w;
    bus.WB_ACK    = a;
    bus.WB_RD_DAT = d;
  endtask

  task automatic sample_acks();
    sb_t e;
    if (bus.M_ACK != '0) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_ack", 32'(bus.M_ACK), 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("sb_ack_owner", 32'(bus.M_ACK), 32'(1 << e.mst));
        chk("sb_rd_dat", bus.M_RD_DAT, e.dat);
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  cyc;
    logic [1:0]  prev_ack;
    logic        ack;
    int          g;
    int          got;
    int          stalls;
    logic        seen;

    adr_tab[0] = 17'h0200C;
    adr_tab[1] = 17'h1F000;
    dat_tab[0] = 32'h0000_0004;
    dat_tab[1] = 32'hA5A5_0001;
    bus.M_ADR      = {adr_tab[1], adr_tab[0]};
    bus.M_WR_DAT   = {dat_tab[1], dat_tab[0]};
    bus.M_BYTE_STB = 8'hFF;
    drive(2'b00, 2'b00, 1'b0, 32'h0);

    //    rst   cyc    we    ack  rdat          wcyc gnt    mack
    addv(1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00);
    addv(1'b1, 2'b01, 2'b01, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00);
    addv(1'b1, 2'b01, 2'b01, 1'b1, 32'h1111_1111, 1'b1, 2'b01, 2'b01);
    addv(1'b1, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 2'b01, 2'b00);
    addv(1'b0, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00);
    addv(1'b1, 2'b11, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00);
    addv(1'b1, 2'b11, 2'b00, 1'b0, 32'h0,        1'b1, 2'b01, 2'b00);
    addv(1'b1, 2'b11, 2'b00, 1'b1, 32'hA1A1_0000, 1'b1, 2'b01, 2'b01);
    addv(1'b1, 2'b10, 2'b00, 1'b0, 32'h0,        1'b0, 2'b01, 2'b00);
    addv(1'b1, 2'b10, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00);
    addv(1'b1, 2'b10, 2'b00, 1'b1, 32'hB2B2_0000, 1'b1, 2'b10, 2'b10);
    addv(1'b1, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 2'b10, 2'b00);
    addv(1'b1, 2'b10, 2'b10, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00);
    addv(1'b1, 2'b10, 2'b10, 1'b1, 32'hC000_0001, 1'b1, 2'b10, 2'b10);
    addv(1'b1, 2'b11, 2'b10, 1'b1, 32'hC000_0002, 1'b1, 2'b10, 2'b10);
    addv(1'b1, 2'b11, 2'b10, 1'b1, 32'hC000_0003, 1'b1, 2'b10, 2'b10);
    addv(1'b1, 2'b11, 2'b10, 1'b0, 32'h0,        1'b1, 2'b10, 2'b00);
    addv(1'b1, 2'b11, 2'b10, 1'b1, 32'hC000_0004, 1'b1, 2'b10, 2'b10);
    addv(1'b1, 2'b01, 2'b00, 1'b0, 32'h0,        1'b0, 2'b10, 2'b00);
    addv(1'b1, 2'b01, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00);
    addv(1'b1, 2'b01, 2'b00, 1'b1, 32'hD0D0_D0D0, 1'b1, 2'b01, 2'b01);
    addv(1'b1, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 2'b01, 2'b00);
    addv(1'b1, 2'b10, 2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00);
    addv(1'b1, 2'b10, 2'b00, 1'b0, 32'h0,        1'b1, 2'b10, 2'b00);
    addv(1'b1, 2'b00, 2'b00, 1'b0, 32'h0,        1'b0, 2'b10, 2'b00);
    addv(1'b1, 2'b00, 2'b00, 1'b1, 32'hEEEE_EEEE, 1'b0, 2'b00, 2'b00);

    foreach (vt[k]) begin
      @(posedge clk); #1;
      rst_n = vt[k].rst_n;
      drive(vt[k].cyc, vt[k].we, vt[k].ack, vt[k].rdat);
      if (vt[k].mack != 2'b00) sbq.push_back('{vt[k].mack[1] ? 1 : 0, vt[k].rdat});
      @(negedge clk);
      g = vt[k].gnt[1] ? 1 : 0;
      chk($sformatf("v%0d_wb_cyc", k), 32'(bus.WB_CYC), 32'(vt[k].wcyc));
      chk($sformatf("v%0d_wb_stb", k), 32'(bus.WB_STB), 32'(vt[k].wcyc));
      chk($sformatf("v%0d_gnt", k), 32'(bus.GNT), 32'(vt[k].gnt));
      chk($sformatf("v%0d_m_ack", k), 32'(bus.M_ACK), 32'(vt[k].mack));
      chk($sformatf("v%0d_m_err", k), 32'(bus.M_ERR), 32'h0);
      chk($sformatf("v%0d_wb_we", k), 32'(bus.WB_WE), 32'(vt[k].wcyc & vt[k].we[g]));
      chk($sformatf("v%0d_wb_rd", k), 32'(bus.WB_RD), 32'(vt[k].wcyc & ~vt[k].we[g]));
      chk($sformatf("v%0d_wb_adr", k), 32'(bus.WB_ADR), vt[k].wcyc ? 32'(adr_tab[g]) : 32'h0);
      chk($sformatf("v%0d_wb_wdat", k), bus.WB_WR_DAT, vt[k].wcyc ? dat_tab[g] : 32'h0);
      chk($sformatf("v%0d_wb_sel", k), 32'(bus.WB_BYTE_STB), vt[k].wcyc ? 32'hF : 32'h0);
      sample_acks();
    end
    chk("sb_drained", 32'(sbq.size()), 32'h0);

    // Reset asserted mid-cycle while master 1 has a beat pending.
    @(posedge clk); #1;
    drive(2'b10, 2'b00, 1'b0, 32'h0);
    @(posedge clk); #3;
    chk("rst_pre_cyc", 32'(bus.WB_CYC), 32'h1);
    bus.WB_ACK = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_cyc", 32'(bus.WB_CYC), 32'h0);
    chk("rst_async_stb", 32'(bus.WB_STB), 32'h0);
    chk("rst_async_gnt", 32'(bus.GNT), 32'h0);
    chk("rst_async_ack", 32'(bus.M_ACK), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(2'b11, 2'b00, 1'b1, 32'h5555_5555);
    @(negedge clk);
    chk("rst_late_ack", 32'(bus.M_ACK), 32'h0);
    @(posedge clk); #1;
    bus.WB_ACK = 1'b0;
    @(negedge clk);
    chk("rst_first_win", 32'(bus.GNT), 32'h1);

    // Continuous requests: each tenancy is one beat, then CYC dips for one cycle.
    pulse_reset();
    cyc = 2'b11;
    prev_ack = 2'b00;
    got = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      if (prev_ack != 2'b00) begin
        cyc = cyc & ~prev_ack;
        ack = 1'b0;
      end else begin
        cyc = 2'b11;
        ack = 1'b1;
      end
      drive(cyc, 2'b00, ack, 32'h0);
      @(negedge clk);
      prev_ack = bus.M_ACK;
      if (bus.M_ACK != 2'b00) begin
        chk($sformatf("rr_order_%0d", got), 32'(bus.M_ACK), (got % 2) ? 32'h2 : 32'h1);
        chk($sformatf("rr_gnt_%0d", got), 32'(bus.GNT), (got % 2) ? 32'h2 : 32'h1);
        got++;
      end
      @(posedge clk); #1;
    end
    chk("rr_tenancies", 32'(got), 32'd6);

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acknowledges: watchdog must error master 0 and hand over to master 1.
    pulse_reset();
    drive(2'b11, 2'b00, 1'b0, 32'h1234_5678);
    stalls = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.GNT == 2'b01) stalls++;
      if (bus.M_ERR != 2'b00) begin
        seen = 1'b1;
        chk("tmo_stall_cnt", 32'(stalls), 32'(TMO));
        chk("tmo_m_ack", 32'(bus.M_ACK), 32'h1);
        chk("tmo_m_err", 32'(bus.M_ERR), 32'h1);
        chk("tmo_rd_dat", bus.M_RD_DAT, 32'hDEAD_BEEF);
        chk("tmo_wb_cyc", 32'(bus.WB_CYC), 32'h0);
      end
    end
    if (!seen) chk("tmo_seen", 32'(bus.M_ERR), 32'h1);
    @(negedge clk);
    chk("tmo_idle_gap", 32'(bus.WB_CYC), 32'h0);
    @(negedge clk);
    chk("tmo_next_gnt", 32'(bus.GNT), 32'h2);
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 1'b0, 32'h0);
`else
    stalls = 0;
    seen = 1'b0;
`endif

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone master port (the upstream side of wishbone_interconnect) between NUM_MASTERS requesters.
- Typical requesters: the MCU bridge plus an FPGA-side DMA/scope readout engine.
- Grants whole bus cycles: a grant is held while the granted master's CYC stays high, so bursts are never split.
- Sits directly in front of wishbone_interconnect; the downstream port uses the same signal set as WB_*.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..4).
- ADDR_WIDTH, 17, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width.
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN).

Ports:
- WB_CLK  in  1  single clock for all logic.
- WB_RST  in  1  asynchronous, active-low reset.
- M_CYC  in  NUM_MASTERS  per-master CYC.
- M_STB  in  NUM_MASTERS  per-master STB.
- M_WE  in  NUM_MASTERS  per-master WE.
- M_RD  in  NUM_MASTERS  per-master RD.
- M_ADR  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- M_WR_DAT  in  NUM_MASTERS*DATA_WIDTH  packed write data.
- M_BYTE_STB  in  NUM_MASTERS*4  packed byte strobes.
- M_ACK  out  NUM_MASTERS  per-master ACK.
- M_ERR  out  NUM_MASTERS  per-master timeout error.
- M_RD_DAT  out  DATA_WIDTH  read data, broadcast to all masters.
- WB_CYC, WB_STB, WB_WE, WB_RD  out  1 each  downstream controls.
- WB_ADR  out  ADDR_WIDTH  downstream address.
- WB_WR_DAT  out  DATA_WIDTH  downstream write data.
- WB_BYTE_STB  out  4  downstream byte strobes.
- WB_RD_DAT  in  DATA_WIDTH  downstream read data.
- WB_ACK  in  1  downstream acknowledge.
- GNT  out  NUM_MASTERS  one-hot current grant (debug).

Behaviour:
- Reset (WB_RST low, asynchronous):
  - State IDLE; GNT=0.
  - All WB_* outputs 0; M_ACK=0; M_ERR=0.
  - Last-grant pointer = NUM_MASTERS-1, so master 0 wins the first arbitration.
- State IDLE:
  - Downstream CYC/STB/WE/RD/BYTE_STB held 0.
  - If any M_CYC is high, register the grant to the first requester after the pointer, searching in increasing index with wrap; go to BUSY.
  - Arbitration latency is 1 cycle: a master raising CYC at edge N sees WB_CYC high from edge N+1.
- State BUSY:
  - All downstream outputs are muxed combinationally from the granted master.
  - M_ACK[g] = WB_ACK; every other M_ACK bit is 0.
  - M_RD_DAT = WB_RD_DAT at all times.
  - Stay in BUSY while M_CYC[g] is high; back-to-back STB/ACK beats pass through with no added latency.
  - When M_CYC[g] is low: go to IDLE, set pointer = g, clear GNT.
  - WB_CYC is low for at least 1 cycle between two tenancies.
- Simultaneous requests: strict round-robin. With both masters continuously requesting, grants alternate 0,1,0,1.
- Non-granted masters:
  - Their STB is ignored; they see ACK=0 and wait.
  - No request queueing beyond holding CYC.
- Granted master drops CYC while a beat is pending (STB high, no ACK):
  - Cycle is abandoned and the downstream CYC/STB drop immediately.
  - A WB_ACK arriving on the next cycle is discarded.
- Reset mid-cycle: all outputs go to reset values asynchronously; a downstream ACK arriving after reset is ignored.
- No combinational path from WB_ACK to any WB_* output.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on every WB_ACK or grant change, and increments each BUSY cycle with WB_STB=1 and WB_ACK=0.
  - When it reaches TIMEOUT_CYCLES: assert M_ACK[g] and M_ERR[g] for exactly 1 cycle, with M_RD_DAT = 0xDEADBEEF.
  - Force WB_CYC/WB_STB low the same cycle, then go to IDLE and set the pointer to g.
- Not defined: no counter is built; M_ERR is tied 0 and TIMEOUT_CYCLES is unused.

Test Plan:
- After reset, master 0 writes 0x4 to 0x0200C:
  - WB_CYC rises 1 cycle after M_CYC[0].
  - WB_ADR=0x0200C, WB_WR_DAT=0x4.
  - M_ACK[0] pulses with WB_ACK; M_ACK[1] stays 0; GNT=01.
- Both masters raise CYC on the same edge, each doing single reads:
  - Master 0 is served first, then master 1 after a 1-cycle WB_CYC gap.
  - Each sees its own ACK; M_RD_DAT carries the slave data.
- Master 1 holds CYC for a 4-beat burst while master 0 requests mid-burst:
  - All 4 beats go to master 1 uninterrupted.
  - Master 0 is granted only after master 1 drops CYC.
- Both masters request continuously for 6 tenancies → grant order is 0,1,0,1,0,1.
- WB_RST pulled low while BUSY with STB pending:
  - WB_CYC and GNT clear immediately.
  - After release, master 0 wins the first arbitration.
- With WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never ACKs:
  - On the 8th stalled cycle M_ACK[g]=M_ERR[g]=1 for 1 cycle and M_RD_DAT=0xDEADBEEF.
  - WB_CYC drops; the other master is then granted.
